// File: rtl/adc_spi_responder.sv
`timescale 1ns/1ps
// adc_spi_responder
// Accepts one conversion request from the mux scan controller, runs a
// 16-SCLK read frame on a 12-bit serial ADC (CPOL=1, sampled on SCLK
// rising), and returns the result tagged with the captured matrix address.
//
// Handshake: a request is taken on any clk edge where adc_start=1 and
// adc_ready=1; adc_ready then stays low until the frame and the quiet gap
// after it are over. Requests while adc_ready=0 are dropped, not queued.
// data_valid is a one-cycle pulse; adc_data/adc_addr hold until the next one.
module adc_spi_responder #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned QUIET    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        adc_start,
   input  logic [7:0]  sample_addr,
   output logic        adc_ready,
   output logic [11:0] adc_data,
   output logic [7:0]  adc_addr,
   output logic        data_valid,
   output logic        spi_cs_n,
   output logic        spi_sclk,
   input  logic        spi_miso,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_DONE  = 3'd3,
      S_QUIET = 3'd4
   } state_t;

   // Terminal counts; all phases count 0..N-1 in an 8-bit counter, so a
   // phase of up to 255 cycles never wraps.
   localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] QUIET_LAST = 8'(QUIET - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;          // cycles within the current phase / half-bit
   logic [3:0]  bit_q, bit_d;          // SCLK period index 0..15
   logic [11:0] shift_q, shift_d;      // the four leading frame bits fall off the top
   logic [7:0]  req_addr_q, req_addr_d;
   logic        ready_q, ready_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        valid_q, valid_d;
   logic [11:0] data_q, data_d;
   logic [7:0]  out_addr_q, out_addr_d;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers; every output comes straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= 8'd0;
         bit_q      <= 4'd0;
         shift_q    <= 12'd0;
         req_addr_q <= 8'd0;
         ready_q    <= 1'b1;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b1;
         valid_q    <= 1'b0;
         data_q     <= 12'd0;
         out_addr_q <= 8'd0;
      end else begin
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         req_addr_q <= req_addr_d;
         ready_q    <= ready_d;
         cs_n_q     <= cs_n_d;
         sclk_q     <= sclk_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         out_addr_q <= out_addr_d;
      end
   end

   // Next-state and next-output logic; outputs are computed for the cycle
   // the FSM is about to enter so they line up with the registered state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      req_addr_d = req_addr_q;
      ready_d    = ready_q;
      cs_n_d     = cs_n_q;
      sclk_d     = sclk_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      out_addr_d = out_addr_q;

      case (state_q)
         S_IDLE: begin
            if (adc_start) begin
               state_d    = S_SETUP;
               cnt_d      = 8'd0;
               req_addr_d = sample_addr;
               ready_d    = 1'b0;
               cs_n_d     = 1'b0;
            end
         end

         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               // First SCLK falling edge opens bit 0.
               state_d = S_SHIFT;
               cnt_d   = 8'd0;
               bit_d   = 4'd0;
               sclk_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_SHIFT: begin
            if (cnt_q != DIV_LAST) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = 8'd0;
               if (!sclk_q) begin
                  // End of low half: raise SCLK and take the bit the ADC
                  // put out after the previous falling edge.
                  sclk_d  = 1'b1;
                  shift_d = {shift_q[10:0], spi_miso};
               end else if (bit_q == 4'd15) begin
                  state_d    = S_DONE;
                  cs_n_d     = 1'b1;
                  valid_d    = 1'b1;
                  data_d     = shift_q;
                  out_addr_d = req_addr_q;
               end else begin
                  bit_d  = bit_q + 4'd1;
                  sclk_d = 1'b0;
               end
            end
         end

         S_DONE: begin
            state_d = S_QUIET;
            cnt_d   = 8'd0;
         end

         S_QUIET: begin
            if (cnt_q == QUIET_LAST) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
         end
      endcase
   end

   assign adc_ready  = ready_q;
   assign adc_data   = data_q;
   assign adc_addr   = out_addr_q;
   assign data_valid = valid_q;
   assign spi_cs_n   = cs_n_q;
   assign spi_sclk   = sclk_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
`timescale 1ns/1ps
// Bench for adc_spi_responder: one instance with default timing, one with
// CLK_DIV=CS_SETUP=QUIET=1. Each has a serial ADC model and a scoreboard
// that predicts acceptance and result timing from the frame arithmetic.
module tb_adc_spi_responder;

   localparam int A_DIV = 4, A_SET = 2, A_QUI = 4;
   localparam int A_N   = A_SET + 32 * A_DIV + 1;   // data_valid cycle, 131
   localparam int B_DIV = 1, B_SET = 1, B_QUI = 1;
   localparam int B_N   = B_SET + 32 * B_DIV + 1;   // 34

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] word;
      logic [11:0] exp_data;
      logic [7:0]  exp_addr;
      bit          extra;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   // ---------------- DUT A (defaults) ----------------
   logic        a_start, a_ready, a_valid, a_cs_n, a_sclk, a_miso = 1'b0;
   logic [7:0]  a_addr_in, a_addr;
   logic [11:0] a_data;
   logic [2:0]  a_state;
   logic [15:0] a_word;

   adc_spi_responder #(.CLK_DIV(A_DIV), .CS_SETUP(A_SET), .QUIET(A_QUI)) u_a (
      .clk(clk), .rst_n(rst_n), .adc_start(a_start), .sample_addr(a_addr_in),
      .adc_ready(a_ready), .adc_data(a_data), .adc_addr(a_addr),
      .data_valid(a_valid), .spi_cs_n(a_cs_n), .spi_sclk(a_sclk),
      .spi_miso(a_miso), .dbg_state(a_state));

   // ---------------- DUT B (fast) ----------------
   logic        b_start, b_ready, b_valid, b_cs_n, b_sclk, b_miso = 1'b0;
   logic [7:0]  b_addr_in, b_addr;
   logic [11:0] b_data;
   logic [2:0]  b_state;
   logic [15:0] b_word;

   adc_spi_responder #(.CLK_DIV(B_DIV), .CS_SETUP(B_SET), .QUIET(B_QUI)) u_b (
      .clk(clk), .rst_n(rst_n), .adc_start(b_start), .sample_addr(b_addr_in),
      .adc_ready(b_ready), .adc_data(b_data), .adc_addr(b_addr),
      .data_valid(b_valid), .spi_cs_n(b_cs_n), .spi_sclk(b_sclk),
      .spi_miso(b_miso), .dbg_state(b_state));

   // ---------------- ADC models: MSB first, update after SCLK falls ----------------
   int a_bit = 15, b_bit = 15, a_rise = 0, b_rise = 0;

   always @(negedge a_sclk or posedge a_cs_n) begin
      if (a_cs_n) a_bit = 15;
      else if (a_bit >= 0) begin a_miso = a_word[a_bit]; a_bit = a_bit - 1; end
   end
   always @(negedge b_sclk or posedge b_cs_n) begin
      if (b_cs_n) b_bit = 15;
      else if (b_bit >= 0) begin b_miso = b_word[b_bit]; b_bit = b_bit - 1; end
   end
   always @(posedge a_sclk) if (!a_cs_n) a_rise = a_rise + 1;
   always @(posedge b_sclk) if (!b_cs_n) b_rise = b_rise + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act === exp) passed = passed + 1;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // ---------------- scoreboards ----------------
   // Entry = {due cycle[31:0], addr[7:0], data[11:0]}. A request is taken when
   // the model says the block is free; it is then busy for N+QUIET cycles.
   logic [51:0] a_exp_q[$];
   logic [51:0] b_exp_q[$];
   logic [51:0] a_e, b_e;
   int a_busy = 0, b_busy = 0;

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         a_busy = 0;
         a_exp_q.delete();
      end else begin
         if (a_valid) begin
            if (a_exp_q.size() == 0) check("a_unexpected_valid", 32'(a_valid), 32'd0);
            else begin
               a_e = a_exp_q.pop_front();
               check("a_sb_cycle", cyc, a_e[51:20]);
               check("a_sb_addr", 32'(a_addr), 32'(a_e[19:12]));
               check("a_sb_data", 32'(a_data), 32'(a_e[11:0]));
            end
         end
         if (a_busy != 0) a_busy = a_busy - 1;
         else if (a_start) begin
            a_exp_q.push_back({32'(cyc + A_N), a_addr_in, a_word[11:0]});
            a_busy = A_N + A_QUI;
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         b_busy = 0;
         b_exp_q.delete();
      end else begin
         if (b_valid) begin
            if (b_exp_q.size() == 0) check("b_unexpected_valid", 32'(b_valid), 32'd0);
            else begin
               b_e = b_exp_q.pop_front();
               check("b_sb_cycle", cyc, b_e[51:20]);
               check("b_sb_addr", 32'(b_addr), 32'(b_e[19:12]));
               check("b_sb_data", 32'(b_data), 32'(b_e[11:0]));
            end
         end
         if (b_busy != 0) b_busy = b_busy - 1;
         else if (b_start) begin
            b_exp_q.push_back({32'(cyc + B_N), b_addr_in, b_word[11:0]});
            b_busy = B_N + B_QUI;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One conversion on A; optional ignored pulses in cycles 50 and 133.
   task automatic single_a(input vec_t v);
      int k_valid, k_ready, n_valid, r0;
      logic [11:0] d;
      logic [7:0]  ad;
      logic cs1, csl, csn;
      k_valid = 0; k_ready = 0; n_valid = 0;
      d = '0; ad = '0; cs1 = 1'b1; csl = 1'b1; csn = 1'b0;
      @(negedge clk);
      a_word = v.word; a_addr_in = v.addr; a_start = 1'b1;
      r0 = a_rise;
      @(posedge clk);                     // T0
      for (int k = 1; k <= 145; k++) begin
         @(negedge clk);
         if (v.extra && (k == 50 || k == 133)) begin a_start = 1'b1; a_addr_in = 8'h11; end
         else a_start = 1'b0;
         #1;
         if (k == 1) cs1 = a_cs_n;
         if (k == A_N - 1) csl = a_cs_n;
         if (k == A_N) csn = a_cs_n;
         if (a_valid) begin
            n_valid++;
            if (k_valid == 0) begin k_valid = k; d = a_data; ad = a_addr; end
         end
         if (a_ready && k_ready == 0) k_ready = k;
      end
      check("a_valid_cycle", k_valid, A_N);
      check("a_valid_count", n_valid, 1);
      check("a_data", 32'(d), 32'(v.exp_data));
      check("a_addr", 32'(ad), 32'(v.exp_addr));
      check("a_ready_cycle", k_ready, A_N + A_QUI + 1);
      check("a_cs_low_c1", 32'(cs1), 0);
      check("a_cs_low_last", 32'(csl), 0);
      check("a_cs_high_done", 32'(csn), 1);
      check("a_sclk_rises", a_rise - r0, 16);
      check("a_data_hold", 32'(a_data), 32'(v.exp_data));
   endtask

   vec_t vecs[5];
   int nv, nready, run, min_run, r0b, k_valid, k_ready, bad;
   int times[3];
   logic [7:0] addrs[3];
   logic pending, seen_low, cs59;

   initial begin
      vecs[0] = '{8'h5A, 16'h0ABC, 12'hABC, 8'h5A, 1'b0};
      vecs[1] = '{8'h3C, 16'hF123, 12'h123, 8'h3C, 1'b0};
      vecs[2] = '{8'hC7, 16'h0FFF, 12'hFFF, 8'hC7, 1'b0};
      vecs[3] = '{8'h5A, 16'h8001, 12'h001, 8'h5A, 1'b1};
      vecs[4] = '{8'hE1, 16'h7E5A, 12'hE5A, 8'hE1, 1'b0};

      rst_n = 1'b0;
      a_start = 1'b0; a_addr_in = 8'h00; a_word = 16'h0000;
      b_start = 1'b0; b_addr_in = 8'h00; b_word = 16'h0000;
      repeat (2) @(negedge clk);
      #2;
      check("rst_a_ready", 32'(a_ready), 1);
      check("rst_a_cs_n", 32'(a_cs_n), 1);
      check("rst_a_sclk", 32'(a_sclk), 1);
      check("rst_a_valid", 32'(a_valid), 0);
      check("rst_a_data", 32'(a_data), 0);
      check("rst_a_addr", 32'(a_addr), 0);
      check("rst_b_ready", 32'(b_ready), 1);
      check("rst_b_cs_n", 32'(b_cs_n), 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven single conversions, including leading-bit discard and
      // the ignored-request vector.
      for (int i = 0; i < 5; i++) single_a(vecs[i]);

      // Held request: address steps on every acceptance.
      @(negedge clk);
      a_addr_in = 8'h00; a_start = 1'b1;
      nv = 0; nready = 0; run = 0; min_run = 1000; pending = 1'b0; seen_low = 1'b0;
      for (int k = 0; k < 600 && nv < 3; k++) begin
         #1;
         if (a_valid) begin times[nv] = cyc; addrs[nv] = a_addr; nv++; end
         if (a_ready && nv >= 1 && nv < 3) nready++;
         if (a_cs_n) run++;
         else begin
            if (seen_low && run > 0 && run < min_run) min_run = run;
            run = 0; seen_low = 1'b1;
         end
         if (a_ready) pending = 1'b1;
         @(negedge clk);
         if (pending) begin a_addr_in = a_addr_in + 8'd1; pending = 1'b0; end
      end
      a_start = 1'b0;
      check("held_count", nv, 3);
      check("held_period_1", times[1] - times[0], 136);
      check("held_period_2", times[2] - times[1], 136);
      check("held_addr_0", 32'(addrs[0]), 32'h00);
      check("held_addr_1", 32'(addrs[1]), 32'h01);
      check("held_addr_2", 32'(addrs[2]), 32'h02);
      check("held_cs_gap_ge5", 32'(min_run >= 5 && min_run < 1000), 1);
      check("held_ready_cycles", nready, 2);
      repeat (10) @(negedge clk);

      // Reset in the middle of SHIFT.
      @(negedge clk);
      a_word = 16'h1234; a_addr_in = 8'h77; a_start = 1'b1;
      cs59 = 1'b1;
      @(posedge clk);
      for (int k = 1; k < 60; k++) begin
         @(negedge clk);
         a_start = 1'b0;
         if (k == 59) begin #1; cs59 = a_cs_n; end
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_was_active", 32'(cs59), 0);
      check("mid_rst_cs_n", 32'(a_cs_n), 1);
      check("mid_rst_sclk", 32'(a_sclk), 1);
      check("mid_rst_ready", 32'(a_ready), 1);
      check("mid_rst_data", 32'(a_data), 0);
      check("mid_rst_addr", 32'(a_addr), 0);
      check("mid_rst_valid", 32'(a_valid), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      repeat (150) begin @(negedge clk); #1; if (a_valid) nv++; end
      check("mid_rst_no_valid", nv, 0);
      single_a(vecs[1]);

      // Fast instance: SCLK toggles every clk cycle.
      @(negedge clk);
      b_word = 16'h0555; b_addr_in = 8'h9C; b_start = 1'b1;
      r0b = b_rise; k_valid = 0; k_ready = 0; bad = 0;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         b_start = 1'b0;
         #1;
         if (k >= B_SET + 1 && k <= B_SET + 32 && b_sclk !== logic'((k - B_SET - 1) % 2)) bad++;
         if (b_valid && k_valid == 0) begin
            k_valid = k;
            check("b_data", 32'(b_data), 32'h555);
            check("b_addr", 32'(b_addr), 32'h9C);
         end
         if (b_ready && k_ready == 0) k_ready = k;
      end
      check("b_valid_cycle", k_valid, 34);
      check("b_ready_cycle", k_ready, 36);
      check("b_sclk_toggle", bad, 0);
      check("b_sclk_rises", b_rise - r0b, 16);

      // Randomized traffic on both instances, checked by the scoreboards.
      for (int k = 0; k < 2500; k++) begin
         @(negedge clk);
         a_start = ($urandom_range(0, 9) == 0);
         a_addr_in = 8'($urandom_range(0, 255));
         if (a_ready && $urandom_range(0, 3) == 0) a_word = 16'($urandom);
         b_start = ($urandom_range(0, 2) == 0);
         b_addr_in = 8'($urandom_range(0, 255));
         if (b_ready && $urandom_range(0, 3) == 0) b_word = 16'($urandom);
      end
      @(negedge clk);
      a_start = 1'b0; b_start = 1'b0;
      repeat (200) @(negedge clk);
      #2;
      check("a_sb_drained", a_exp_q.size(), 0);
      check("b_sb_drained", b_exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
      $fatal(1, "timeout");
   end

endmodule
